// File: rtl/guess_checker_if.sv
// Host/guest word inputs and score outputs of the word-game checker.
// master drives the words and pulses; slave is the checker itself.
interface guess_checker_if;
    logic [39:0] host_word;
    logic        host_load;
    logic [39:0] guess_word;
    logic        guess_valid;
    logic        busy;
    logic [9:0]  result;
    logic        result_valid;
    logic        win;
    logic [2:0]  guess_count;
    logic        gameEnd;

    modport master (
        output host_word, host_load, guess_word, guess_valid,
        input  busy, result, result_valid, win, guess_count, gameEnd
    );

    modport slave (
        input  host_word, host_load, guess_word, guess_valid,
        output busy, result, result_valid, win, guess_count, gameEnd
    );
endinterface

// File: rtl/guess_checker.sv
// Scores a five-letter guess against the host word (green/yellow/gray), 7-clock latency.
// No backpressure: a guess arriving while scoring, unloaded or after game end is dropped.
module guess_checker #(
    parameter int NUM_GUESSES = 6
) (
    input  logic           clk,
    input  logic           rst,
    guess_checker_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_GREEN, ST_YELLOW, ST_DONE} state_t;

    localparam logic [3:0] MAX_GUESSES = 4'(NUM_GUESSES);

    state_t      state, state_nxt;
    logic [39:0] secret, guess;
    logic        loaded;
    logic [4:0]  green, used;
    logic [9:0]  res;
    logic [2:0]  p;

    logic [9:0]  result_r;
    logic        result_valid_r, win_r, game_end_r, busy_r;
    logic [2:0]  guess_count_r;

    logic        accept, do_load, commit;

    logic [7:0]  sec_b [5];
    logic [7:0]  gss_b [5];
    logic [4:0]  green_cmp;
    logic [9:0]  res_green;

    logic [7:0]  gss_p;
    logic        green_p, yel_hit;
    logic [4:0]  cand, first, used_step;
    logic [9:0]  res_step;

    logic [3:0]  cnt_inc;
    logic [2:0]  cnt_sat;
    logic        win_nxt;

    for (genvar i = 0; i < 5; i++) begin : g_pos
        assign sec_b[i]              = secret[39-8*i -: 8];
        assign gss_b[i]              = guess[39-8*i -: 8];
        assign green_cmp[i]          = (sec_b[i] == gss_b[i]);
        assign res_green[9-2*i -: 2] = green_cmp[i] ? 2'b10 : 2'b00;
    end

    // Yellow search for position p: lowest secret letter not yet credited.
    always_comb begin
        gss_p   = 8'h00;
        green_p = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (p == 3'(i)) begin
                gss_p   = gss_b[i];
                green_p = green[i];
            end
        end
        cand = '0;
        for (int j = 0; j < 5; j++) begin
            cand[j] = !used[j] && (sec_b[j] == gss_p);
        end
        first     = cand & (~cand + 5'd1);
        yel_hit   = !green_p && (cand != 5'd0);
        used_step = yel_hit ? (used | first) : used;
        res_step  = res;
        for (int i = 0; i < 5; i++) begin
            if (yel_hit && (p == 3'(i))) begin
                res_step[9-2*i -: 2] = 2'b01;
            end
        end
    end

    assign cnt_inc = {1'b0, guess_count_r} + 4'd1;
    assign cnt_sat = (cnt_inc >= MAX_GUESSES) ? MAX_GUESSES[2:0] : cnt_inc[2:0];
    assign win_nxt = &green;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The score is committed on the edge leaving the last yellow step, so the
    // ST_DONE cycle is the result_valid cycle and may already take the next guess.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_load   = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.host_load) begin
                    do_load = 1'b1;
                end else if (bus.guess_valid && loaded && !game_end_r) begin
                    accept    = 1'b1;
                    state_nxt = ST_GREEN;
                end
            end
            ST_GREEN: state_nxt = ST_YELLOW;
            ST_YELLOW: begin
                if (p == 3'd4) begin
                    commit    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.guess_valid && !bus.host_load && loaded && !game_end_r) begin
                    accept    = 1'b1;
                    state_nxt = ST_GREEN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secret         <= '0;
            guess          <= '0;
            loaded         <= 1'b0;
            green          <= '0;
            used           <= '0;
            res            <= '0;
            p              <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            win_r          <= 1'b0;
            game_end_r     <= 1'b0;
            guess_count_r  <= '0;
            busy_r         <= 1'b0;
        end else begin
            result_valid_r <= commit;
            busy_r         <= (state_nxt != ST_IDLE);

            if (do_load) begin
                secret        <= bus.host_word;
                loaded        <= 1'b1;
                guess_count_r <= '0;
                win_r         <= 1'b0;
                game_end_r    <= 1'b0;
                result_r      <= '0;
            end

            if (accept) begin
                guess <= bus.guess_word;
                res   <= '0;
            end

            if (state == ST_GREEN) begin
                green <= green_cmp;
                used  <= green_cmp;
                res   <= res_green;
                p     <= '0;
            end

            if (state == ST_YELLOW) begin
                res  <= res_step;
                used <= used_step;
                if (p != 3'd4) begin
                    p <= p + 3'd1;
                end
            end

            if (commit) begin
                result_r      <= res_step;
                guess_count_r <= cnt_sat;
                win_r         <= win_nxt;
                game_end_r    <= win_nxt || (cnt_inc >= MAX_GUESSES);
            end
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.win          = win_r;
    assign bus.guess_count  = guess_count_r;
    assign bus.gameEnd      = game_end_r;
endmodule

// File: tb/tb_guess_checker.sv
// Scoreboarded random/directed bench for guess_checker; expectations come
// from a letter-count scoring model, checked by a negedge monitor.
module tb_guess_checker;
    logic tb_clk = 1'b0;
    logic rst    = 1'b1;

    guess_checker_if bus ();

    guess_checker #(.NUM_GUESSES(6)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [9:0] res;
        logic       win;
        logic [2:0] cnt;
        logic       gend;
        int         cyc;
    } exp_t;

    exp_t sb [$];
    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    localparam logic [39:0] FANTA = 40'h46414E5441;
    localparam logic [39:0] AAAAA = 40'h4141414141;
    localparam logic [39:0] TAFFY = 40'h5441464659;

    logic [39:0] m_secret = '0;
    bit          m_loaded = 0;
    int          m_count  = 0;
    bit          m_end    = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Greens first; remaining secret letters are a multiset handed out left to right.
    function automatic logic [9:0] ref_score(input logic [39:0] s, input logic [39:0] g);
        int cnt [256];
        bit gr [5];
        logic [7:0] sl, gl;
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < 256; k++) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            sl = s[39-8*i -: 8];
            gl = g[39-8*i -: 8];
            gr[i] = (sl == gl);
            if (gr[i]) r[9-2*i -: 2] = 2'b10;
            else       cnt[sl]++;
        end
        for (int i = 0; i < 5; i++) begin
            gl = g[39-8*i -: 8];
            if (!gr[i] && cnt[gl] > 0) begin
                r[9-2*i -: 2] = 2'b01;
                cnt[gl]--;
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] rand_word();
        logic [7:0] alpha [6] = '{8'h46, 8'h41, 8'h4E, 8'h54, 8'h58, 8'h59};
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w[39-8*i -: 8] = alpha[$urandom_range(0, 5)];
        return w;
    endfunction

    function automatic logic [39:0] rand_losing_word();
        logic [39:0] w;
        w = rand_word();
        if (w == m_secret) w[7:0] = 8'h5A;
        return w;
    endfunction

    always @(negedge tb_clk) begin
        if (!rst && bus.result_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_result_valid: result %b at cycle %0d, none expected", bus.result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",       bus.result,      e.res);
                check("win",          bus.win,         e.win);
                check("guess_count",  bus.guess_count, e.cnt);
                check("gameEnd",      bus.gameEnd,     e.gend);
                check("latency_cyc",  cyc,             e.cyc);
            end
        end
    end

    task automatic drive_guess(input logic [39:0] g);
        bit acc;
        exp_t e;
        logic [9:0] r;
        acc = m_loaded && !m_end;
        e.cyc = cyc + 7;
        bus.guess_word  = g;
        bus.guess_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.guess_valid = 1'b0;
        check("busy_after_guess", bus.busy, acc);
        if (acc) begin
            r = ref_score(m_secret, g);
            if (m_count < 6) m_count++;
            e.res  = r;
            e.win  = (r == 10'h2AA);
            e.cnt  = 3'(m_count);
            e.gend = e.win || (m_count >= 6);
            m_end  = e.gend;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge tb_clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL result_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic load_host(input logic [39:0] w);
        @(negedge tb_clk);
        bus.host_word = w;
        bus.host_load = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.host_load = 1'b0;
        m_secret = w; m_loaded = 1; m_count = 0; m_end = 0;
        check("load_guess_count", bus.guess_count, 0);
        check("load_gameEnd",     bus.gameEnd,     0);
        check("load_win",         bus.win,         0);
        check("load_result",      bus.result,      0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},         bus.busy,         0);
        check({tag, "_result"},       bus.result,       0);
        check({tag, "_result_valid"}, bus.result_valid, 0);
        check({tag, "_win"},          bus.win,          0);
        check({tag, "_guess_count"},  bus.guess_count,  0);
        check({tag, "_gameEnd"},      bus.gameEnd,      0);
    endtask

    task automatic model_reset();
        m_loaded = 0; m_count = 0; m_end = 0;
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.host_word   = '0;
        bus.host_load   = 1'b0;
        bus.guess_word  = '0;
        bus.guess_valid = 1'b0;

        repeat (3) @(negedge tb_clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Guess before any host word: dropped.
        @(negedge tb_clk);
        drive_guess(FANTA);
        repeat (10) @(negedge tb_clk);

        // host_load and guess_valid together: the load wins.
        bus.host_word   = FANTA;
        bus.host_load   = 1'b1;
        bus.guess_word  = FANTA;
        bus.guess_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.host_load   = 1'b0;
        bus.guess_valid = 1'b0;
        m_secret = FANTA; m_loaded = 1; m_count = 0; m_end = 0;
        check("load_vs_guess_busy", bus.busy, 0);
        repeat (10) @(negedge tb_clk);

        drive_guess(FANTA);
        wait_drain();
        drive_guess(TAFFY);
        repeat (10) @(negedge tb_clk);

        // Asynchronous reset mid-cycle with nonzero outputs.
        check("pre_reset_win", bus.win, 1);
        @(posedge tb_clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge tb_clk);
        rst = 1'b0;
        model_reset();

        load_host(FANTA);
        drive_guess(AAAAA);
        wait_drain();
        drive_guess(TAFFY);
        wait_drain();
        for (int k = 0; k < 4; k++) begin
            drive_guess(rand_losing_word());
            wait_drain();
            repeat ($urandom_range(0, 2)) @(negedge tb_clk);
        end
        drive_guess(rand_losing_word());
        repeat (10) @(negedge tb_clk);
        load_host(FANTA);

        // Extra guess_valid during scoring must not produce a second result.
        drive_guess(rand_losing_word());
        repeat (3) @(posedge tb_clk);
        #1;
        bus.guess_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.guess_valid = 1'b0;
        wait_drain();
        repeat (10) @(negedge tb_clk);

        for (int gm = 0; gm < 4; gm++) begin
            load_host(rand_word());
            for (int k = 0; k < 8; k++) begin
                if (m_end) break;
                drive_guess(($urandom_range(0, 3) == 0) ? m_secret : rand_word());
                wait_drain();
                repeat ($urandom_range(0, 2)) @(negedge tb_clk);
            end
            drive_guess(rand_word());
            repeat (10) @(negedge tb_clk);
        end

        // Reset during the yellow pass aborts scoring.
        load_host(FANTA);
        drive_guess(TAFFY);
        repeat (3) @(posedge tb_clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("yellow_reset_busy",         bus.busy,         0);
        check("yellow_reset_guess_count",  bus.guess_count,  0);
        check("yellow_reset_result_valid", bus.result_valid, 0);
        @(negedge tb_clk);
        rst = 1'b0;
        repeat (12) @(negedge tb_clk);
        drive_guess(TAFFY);
        repeat (12) @(negedge tb_clk);
        check("yellow_reset_guess_count_after", bus.guess_count, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/guess_checker.md
# guess_checker

Scores a guest guess against the host's secret word for the five-letter word game. Sits directly downstream of the host message register: it loads the 40-bit host word when the host commits it, then per-letter scores each 40-bit guess, sequentially over several cycles, into exact (green) / present (yellow) / absent (gray) codes. It also tracks the guess count and drives the game-end flag to the display and game FSMs.

## Interface
- `NUM_GUESSES`, default 6: guesses allowed before the game ends.
- `clk`  input  1  system clock
- `rst`  input  1  asynchronous, active-high reset
- `host_word`  input  40  host secret word, 5 ASCII bytes; position 0 = bits [39:32], position 4 = bits [7:0]
- `host_load`  input  1  one-cycle pulse; latch `host_word` and start a new game
- `guess_word`  input  40  guest guess, same byte layout
- `guess_valid`  input  1  one-cycle pulse; request scoring of `guess_word`
- `busy`  output  1  scoring in progress (ST_GREEN through ST_DONE)
- `result`  output  10  per-position code, position 0 = bits [9:8]; 2'b10 green, 2'b01 yellow, 2'b00 gray, 2'b11 never produced
- `result_valid`  output  1  one-cycle pulse; `result` holds a new score
- `win`  output  1  last scored guess matched all five positions
- `guess_count`  output  3  guesses scored this game, saturates at `NUM_GUESSES`
- `gameEnd`  output  1  game over (win or guesses exhausted); held until next `host_load`

## Operation
- Registers: `secret[39:0]`, `guess[39:0]`, `loaded`, `green[4:0]`, `used[4:0]`, `res[9:0]`, position counter `p[2:0]`, plus outputs. All outputs are registered.
- States: ST_IDLE, ST_GREEN, ST_YELLOW, ST_DONE.
- ST_IDLE, `host_load`=1:
  - Latch `secret`.
  - Set `loaded`=1.
  - Clear `guess_count`, `win`, `gameEnd`, `result`.
  - Stay in ST_IDLE.
- ST_IDLE, `guess_valid`=1, `host_load`=0, `loaded`=1, `gameEnd`=0:
  - Latch `guess` and clear `res`.
  - Go to ST_GREEN.
- Any other `guess_valid` is dropped silently. This covers: arriving while busy, arriving before a host word is loaded, arriving after game end, and arriving in the same cycle as `host_load`. In the last case the load wins.
- `host_load` outside ST_IDLE is ignored.
- ST_GREEN (1 cycle):
  - `green[i]` = (guess byte i == secret byte i), exact 8-bit compare, all five in parallel.
  - `used` <= `green`.
  - `res` codes set to 2'b10 where green.
  - `p` <= 0; go to ST_YELLOW.
- ST_YELLOW (exactly 5 cycles, one per position p = 0..4):
  - If `green[p]`=0, find the lowest j with `used[j]`=0 and secret byte j == guess byte p.
  - If such a j exists, set `res[p]` = 2'b01 and `used[j]` = 1.
  - Otherwise `res[p]` stays 2'b00.
  - After p = 4, go to ST_DONE.
- Duplicate letters: each secret letter credits at most one guess position. Greens take priority; yellows are assigned left to right.
- ST_DONE (1 cycle):
  - `result` <= `res`, `result_valid` <= 1.
  - `guess_count` <= `guess_count`+1, saturating.
  - `win` <= (`green` == 5'b11111).
  - `gameEnd` <= win OR (`guess_count`+1 >= `NUM_GUESSES`).
  - Return to ST_IDLE.
- `result` and `win` hold their values until the next ST_DONE or `host_load`.

## Timing
- Reset (async assert): state ST_IDLE; `busy`, `result`, `result_valid`, `win`, `guess_count`, `gameEnd`, `loaded` all 0.
- Reset mid-scoring aborts immediately. No `result_valid` is produced, and `guess_count` is not incremented.
- `guess_valid` sampled at edge 0:
  - `busy` rises after edge 0.
  - `result_valid` is high for the single cycle after edge 6 (latency 7 clocks).
  - `busy` falls after edge 7.
- `result`, `win`, `gameEnd`, `guess_count` update at the same edge that raises `result_valid`.
- Earliest next accepted guess: sampled at edge 7. Back-to-back throughput is 1 guess per 7 cycles.
- `host_load` takes effect at the sampling edge; the new `secret` is used by the next accepted guess.

## Test plan
- Reset: assert `rst` mid-cycle with outputs nonzero -> all outputs 0 immediately, state ST_IDLE. A `guess_valid` before any `host_load` -> no `result_valid`.
- Host "FANTA" (0x46414E5441), guess "FANTA" -> `result_valid` 7 clocks later, `result`=10'b1010101010, `win`=1, `guess_count`=1, `gameEnd`=1. A further `guess_valid` is ignored.
- Host "FANTA", guess "AAAAA" -> `result`=10'b0010000010 (greens at positions 1 and 4, no yellows), `win`=0.
- Host "FANTA", guess "TAFFY" -> `result`=10'b0110010000. Checks T yellow, A green, first F yellow, second F gray (secret F already used), Y gray.
- Six non-winning guesses -> `guess_count` 1..6, `gameEnd`=1 on the sixth `result_valid`. Seventh guess gives no `result_valid`. `host_load` then clears `gameEnd` and `guess_count`.
- `guess_valid` pulsed while `busy` -> only one `result_valid`. `rst` pulsed during ST_YELLOW -> `busy`=0, no `result_valid`, `guess_count` unchanged at 0.
